// File: rtl/rca_lsq_row_arbiter.sv
//------------------------------------------------------------------------------
// rca_lsq_row_arbiter : round-robin sharing of the RCA LSQ between grid rows
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rca_lsq_row_arbiter #(
  parameter int NUM_ROWS        = 4,
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ROW_ID_W        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_ROWS-1:0]      req_valid,
  input  logic [NUM_ROWS*XLEN-1:0] req_addr,
  input  logic [NUM_ROWS*XLEN-1:0] req_data,
  input  logic [NUM_ROWS*3-1:0]    req_fn3,
  input  logic [NUM_ROWS-1:0]      req_load,
  input  logic [NUM_ROWS-1:0]      req_store,
  output logic [NUM_ROWS-1:0]      req_ready,
  output logic                     lsq_valid,
  output logic [XLEN-1:0]          lsq_addr,
  output logic [XLEN-1:0]          lsq_data,
  output logic [2:0]               lsq_fn3,
  output logic                     lsq_load,
  output logic                     lsq_store,
  output logic [ROW_ID_W-1:0]      lsq_row_id,
  input  logic                     lsq_ready,
  input  logic                     resp_valid,
  input  logic [ROW_ID_W-1:0]      resp_row_id,
  input  logic [XLEN-1:0]          resp_data,
  output logic [NUM_ROWS-1:0]      load_complete,
  output logic [NUM_ROWS*XLEN-1:0] load_data,
  input  logic                     quiesce,
  output logic                     quiesced,
  output logic                     err
);

  localparam logic [1:0]       c_RUN   = 2'd0;
  localparam logic [1:0]       c_DRAIN = 2'd1;
  localparam logic [1:0]       c_QUIET = 2'd2;
  localparam logic [CNT_W-1:0] c_MAX   = CNT_W'(MAX_OUTSTANDING);

  logic [1:0]          r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt [NUM_ROWS];
  logic [ROW_ID_W-1:0] r_last, w_gnt_idx;
  logic [NUM_ROWS-1:0] w_elig, w_inc, w_dec;
  logic                w_found, w_grant, w_slot_free, w_resp_hit, w_cnt_zero;
  logic [XLEN-1:0]     w_sel_addr, w_sel_data;
  logic [2:0]          w_sel_fn3;
  logic                w_sel_load, w_sel_store;

  logic                     r_lsq_valid, r_lsq_load, r_lsq_store, r_err;
  logic [XLEN-1:0]          r_lsq_addr, r_lsq_data;
  logic [2:0]               r_lsq_fn3;
  logic [ROW_ID_W-1:0]      r_lsq_row_id;
  logic [NUM_ROWS-1:0]      r_load_complete;
  logic [NUM_ROWS*XLEN-1:0] r_load_data;

  assign w_slot_free = !r_lsq_valid || lsq_ready;
  assign w_grant     = w_found && w_slot_free;

  always_comb begin
    w_elig     = '0;
    w_resp_hit = 1'b0;
    w_cnt_zero = 1'b1;
    for (int r = 0; r < NUM_ROWS; r++) begin
      w_elig[r] = req_valid[r] && (req_load[r] || req_store[r]) &&
                  (!req_load[r] || (r_cnt[r] < c_MAX)) && (r_state == c_RUN);
      // Row-by-row match also rejects tags beyond NUM_ROWS.
      if ((resp_row_id == ROW_ID_W'(r)) && (r_cnt[r] != '0))
        w_resp_hit = 1'b1;
      if (r_cnt[r] != '0)
        w_cnt_zero = 1'b0;
    end
  end

  // Search starts one past the previous winner and wraps around.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int i = 1; i <= NUM_ROWS; i++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (!w_found && w_elig[r] && (((int'(r_last) + i) % NUM_ROWS) == r)) begin
          w_found   = 1'b1;
          w_gnt_idx = ROW_ID_W'(r);
        end
      end
    end
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_data  = '0;
    w_sel_fn3   = '0;
    w_sel_load  = 1'b0;
    w_sel_store = 1'b0;
    req_ready   = '0;
    w_inc       = '0;
    w_dec       = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (w_gnt_idx == ROW_ID_W'(r)) begin
        w_sel_addr  = req_addr[r*XLEN +: XLEN];
        w_sel_data  = req_data[r*XLEN +: XLEN];
        w_sel_fn3   = req_fn3[r*3 +: 3];
        w_sel_load  = req_load[r];
        w_sel_store = req_store[r];
      end
      req_ready[r] = w_grant && (w_gnt_idx == ROW_ID_W'(r));
      w_inc[r]     = req_ready[r] && req_load[r];
      w_dec[r]     = resp_valid && w_resp_hit && (resp_row_id == ROW_ID_W'(r));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_RUN:   if (quiesce) w_state_nxt = c_DRAIN;
      c_DRAIN: begin
        if (!quiesce)
          w_state_nxt = c_RUN;
        else if (!r_lsq_valid && w_cnt_zero)
          w_state_nxt = c_QUIET;
      end
      c_QUIET: if (!quiesce) w_state_nxt = c_RUN;
      default: w_state_nxt = c_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= c_RUN;
      r_last          <= ROW_ID_W'(NUM_ROWS - 1);
      r_lsq_valid     <= 1'b0;
      r_lsq_addr      <= '0;
      r_lsq_data      <= '0;
      r_lsq_fn3       <= '0;
      r_lsq_load      <= 1'b0;
      r_lsq_store     <= 1'b0;
      r_lsq_row_id    <= '0;
      r_load_complete <= '0;
      r_load_data     <= '0;
      r_err           <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) r_cnt[r] <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_load_complete <= w_dec;
      if (resp_valid && !w_resp_hit)
        r_err <= 1'b1;
      if (w_grant) begin
        r_last       <= w_gnt_idx;
        r_lsq_valid  <= 1'b1;
        r_lsq_addr   <= w_sel_addr;
        r_lsq_data   <= w_sel_data;
        r_lsq_fn3    <= w_sel_fn3;
        r_lsq_load   <= w_sel_load;
        r_lsq_store  <= w_sel_store && !w_sel_load;
        r_lsq_row_id <= w_gnt_idx;
      end else if (lsq_ready) begin
        r_lsq_valid <= 1'b0;
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (w_dec[r])
          r_load_data[r*XLEN +: XLEN] <= resp_data;
        if (w_inc[r] && !w_dec[r])
          r_cnt[r] <= r_cnt[r] + CNT_W'(1);
        else if (w_dec[r] && !w_inc[r])
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
      end
    end
  end

  assign lsq_valid     = r_lsq_valid;
  assign lsq_addr      = r_lsq_addr;
  assign lsq_data      = r_lsq_data;
  assign lsq_fn3       = r_lsq_fn3;
  assign lsq_load      = r_lsq_load;
  assign lsq_store     = r_lsq_store;
  assign lsq_row_id    = r_lsq_row_id;
  assign load_complete = r_load_complete;
  assign load_data     = r_load_data;
  assign quiesced      = (r_state == c_QUIET);
  assign err           = r_err;

endmodule

`default_nettype wire
